// File: rtl/vram_arbiter.sv
// Shares one single-port 16-bit VRAM between scanout (absolute priority), the CPU MMIO port and a fill engine.
// Define VRAM_ARB_FILL_EN to build the fill engine; otherwise the CPU is the only non-scan requester.
module vram_arbiter #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          scan_req,
    input  logic [AW-1:0] scan_addr,
    output logic          scan_valid,
    output logic [15:0]   scan_rdata,
    input  logic          sel,
    input  logic [3:0]    wstrb,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic          ready,
    output logic [15:0]   rdata,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW:0]   fill_count,
    input  logic [15:0]   fill_value,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [1:0]    ram_wmask,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_wdata,
    input  logic [15:0]   ram_rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_PEND, S_WR_ACK, S_RD_WAIT, S_RD_ACK, S_HOLD
    } cpu_state_t;

    cpu_state_t    r_state, w_state_nxt;
    logic          r_ready, w_ready_nxt;
    logic [15:0]   r_rdata;
    logic [1:0]    r_scan_vld;
    logic          r_ram_en, r_ram_we;
    logic [1:0]    r_ram_wmask;
    logic [AW-1:0] r_ram_addr;
    logic [15:0]   r_ram_wdata;

    logic          w_cpu_wr, w_cpu_nop, w_cpu_req;
    logic          w_fill_req, w_gnt_cpu, w_gnt_fill;
    logic [AW-1:0] w_fill_addr;
    logic [15:0]   w_fill_val;

    // Upper-byte-only strobes have no RAM behind them: acknowledged without an access.
    assign w_cpu_wr  = |wstrb[1:0];
    assign w_cpu_nop = ~w_cpu_wr & (|wstrb[3:2]);
    assign w_cpu_req = sel & (((r_state == S_IDLE) & ~w_cpu_nop) | (r_state == S_PEND));

`ifdef VRAM_ARB_FILL_EN
    localparam logic [AW:0] LAST = (AW+1)'(1);

    logic          r_fill_busy, r_fill_done, r_ptr_cpu;
    logic [AW-1:0] r_fill_addr;
    logic [AW:0]   r_fill_left;
    logic [15:0]   r_fill_val;

    // r_ptr_cpu=1: CPU wins the next CPU/fill conflict (fill was granted last).
    assign w_fill_req  = r_fill_busy;
    assign w_gnt_cpu   = ~scan_req & w_cpu_req & (~w_fill_req | r_ptr_cpu);
    assign w_gnt_fill  = ~scan_req & w_fill_req & ~w_gnt_cpu;
    assign w_fill_addr = r_fill_addr;
    assign w_fill_val  = r_fill_val;
    assign fill_busy   = r_fill_busy;
    assign fill_done   = r_fill_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
            r_ptr_cpu   <= 1'b1;
            r_fill_addr <= '0;
            r_fill_left <= '0;
            r_fill_val  <= '0;
        end else begin
            r_fill_done <= 1'b0;
            if (w_gnt_fill) begin
                r_fill_addr <= r_fill_addr + AW'(1);
                r_fill_left <= r_fill_left - LAST;
                if (r_fill_left == LAST) begin
                    r_fill_busy <= 1'b0;
                    r_fill_done <= 1'b1;
                end
            end else if (!r_fill_busy && fill_start) begin
                if (fill_count != '0) begin
                    r_fill_busy <= 1'b1;
                    r_fill_addr <= fill_base;
                    r_fill_left <= fill_count;
                    r_fill_val  <= fill_value;
                end else begin
                    r_fill_done <= 1'b1;
                end
            end
            if (w_gnt_cpu)       r_ptr_cpu <= 1'b0;
            else if (w_gnt_fill) r_ptr_cpu <= 1'b1;
        end
    end
`else
    logic w_unused_fill;

    assign w_unused_fill = ^{fill_start, fill_base, fill_count, fill_value};
    assign w_fill_req    = 1'b0;
    assign w_gnt_cpu     = ~scan_req & w_cpu_req;
    assign w_gnt_fill    = 1'b0;
    assign w_fill_addr   = '0;
    assign w_fill_val    = '0;
    assign fill_busy     = 1'b0;
    assign fill_done     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sel) begin
                    if (w_cpu_nop) begin
                        w_state_nxt = S_HOLD;
                        w_ready_nxt = 1'b1;
                    end else if (w_gnt_cpu) begin
                        w_state_nxt = w_cpu_wr ? S_WR_ACK : S_RD_WAIT;
                    end else begin
                        w_state_nxt = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (!sel)           w_state_nxt = S_IDLE;
                else if (w_gnt_cpu) w_state_nxt = w_cpu_wr ? S_WR_ACK : S_RD_WAIT;
            end
            S_WR_ACK: begin
                w_state_nxt = S_HOLD;
                w_ready_nxt = 1'b1;
            end
            S_RD_WAIT: w_state_nxt = S_RD_ACK;
            S_RD_ACK: begin
                w_state_nxt = S_HOLD;
                w_ready_nxt = 1'b1;
            end
            // HOLD is the ready cycle; sel is ignored so a slow master cannot re-trigger.
            S_HOLD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_scan_vld <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready    <= w_ready_nxt;
            r_scan_vld <= {r_scan_vld[0], scan_req};
            if (r_state == S_RD_ACK) r_rdata <= ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_wmask <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_en <= scan_req | w_gnt_cpu | w_gnt_fill;
            if (scan_req) begin
                r_ram_we    <= 1'b0;
                r_ram_wmask <= '0;
                r_ram_addr  <= scan_addr;
            end else if (w_gnt_cpu) begin
                r_ram_we    <= w_cpu_wr;
                r_ram_wmask <= wstrb[1:0];
                r_ram_addr  <= addr;
                r_ram_wdata <= wdata;
            end else if (w_gnt_fill) begin
                r_ram_we    <= 1'b1;
                r_ram_wmask <= 2'b11;
                r_ram_addr  <= w_fill_addr;
                r_ram_wdata <= w_fill_val;
            end else begin
                r_ram_we    <= 1'b0;
                r_ram_wmask <= '0;
            end
        end
    end

    assign scan_valid = r_scan_vld[1];
    assign scan_rdata = ram_rdata;
    assign ready      = r_ready;
    assign rdata      = r_rdata;
    assign ram_en     = r_ram_en;
    assign ram_we     = r_ram_we;
    assign ram_wmask  = r_ram_wmask;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: CPU vector table plus scan, reset and fill sequences against a 4K x 16 RAM model.
module tb_vram_arbiter;
    localparam int AW = 12;

    logic          clk, resetn;
    logic          scan_req, scan_valid;
    logic [AW-1:0] scan_addr;
    logic [15:0]   scan_rdata;
    logic          sel, ready;
    logic [3:0]    wstrb;
    logic [AW-1:0] addr;
    logic [15:0]   wdata, rdata;
    logic          fill_start, fill_busy, fill_done;
    logic [AW-1:0] fill_base;
    logic [AW:0]   fill_count;
    logic [15:0]   fill_value;
    logic          ram_en, ram_we;
    logic [1:0]    ram_wmask;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata, ram_rdata;

    vram_arbiter #(.AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_valid(scan_valid), .scan_rdata(scan_rdata),
        .sel(sel), .wstrb(wstrb), .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata),
        .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_wmask(ram_wmask), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: every word starts as {4'hC, address}; registered read.
    logic [15:0] mem [0:4095];
    logic [15:0] r_rd;
    bit          r_init_done;
    always @(posedge clk) begin
        if (!r_init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= {4'hC, 12'(i)};
            r_init_done <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) begin
                if (ram_wmask[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
                if (ram_wmask[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
            end else begin
                r_rd <= mem[ram_addr];
            end
        end
    end
    assign ram_rdata = r_rd;

    typedef struct {
        logic          we;
        logic [1:0]    m;
        logic [AW-1:0] a;
        logic [15:0]   d;
    } acc_t;
    acc_t log_q[$];
    always @(posedge clk) if (ram_en) log_q.push_back('{ram_we, ram_wmask, ram_addr, ram_wdata});

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] strb;
        logic [11:0] a;
        logic [15:0] d;
        int         lat;
        logic [15:0] rd;
        logic [1:0] m;
    } vec_t;

    // One CPU transaction started at a negedge (cycle G); lat counts cycles from G to ready, -1 on timeout.
    task automatic cpu_op(input vec_t v, output int lat, output logic [15:0] rd,
                          output logic en1, output logic we1, output logic [1:0] m1, output logic [11:0] a1);
        @(negedge clk);
        sel = 1'b1; wstrb = v.strb; addr = v.a; wdata = v.d;
        lat = -1; rd = '0; en1 = 1'b0; we1 = 1'b0; m1 = '0; a1 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                en1 = ram_en; we1 = ram_we; m1 = ram_wmask; a1 = ram_addr;
            end
            if (ready) begin
                lat = c; rd = rdata;
                sel = 1'b0; wstrb = '0;
                break;
            end
        end
        if (lat < 0) sel = 1'b0;
    endtask

    vec_t        tv[9];
    int          lat, vcnt, vfirst, cpu_at, rdy_at, rdy_n, done_n, done_at, busy_n, n2222, n1111;
    logic [15:0] rd;
    logic        en1, we1, nop;
    logic [1:0]  m1;
    logic [11:0] a1;
    logic [11:0] wrap_a[4];

    initial begin
        tv[0] = '{"wr_a55a",   4'b0011, 12'h010, 16'hA55A, 2, 16'h0000, 2'b11};
        tv[1] = '{"rd_a55a",   4'b0000, 12'h010, 16'h0000, 3, 16'hA55A, 2'b00};
        tv[2] = '{"wr_hibyte", 4'b0010, 12'h010, 16'h12FF, 2, 16'h0000, 2'b10};
        tv[3] = '{"rd_125a",   4'b0000, 12'h010, 16'h0000, 3, 16'h125A, 2'b00};
        tv[4] = '{"wr_lobyte", 4'b0001, 12'h3FF, 16'hBEEF, 2, 16'h0000, 2'b01};
        tv[5] = '{"rd_c3ef",   4'b0000, 12'h3FF, 16'h0000, 3, 16'hC3EF, 2'b00};
        tv[6] = '{"nop_strb",  4'b1100, 12'h020, 16'hFFFF, 1, 16'h0000, 2'b00};
        tv[7] = '{"rd_c020",   4'b0000, 12'h020, 16'h0000, 3, 16'hC020, 2'b00};
        tv[8] = '{"rd_cfff",   4'b0000, 12'hFFF, 16'h0000, 3, 16'hCFFF, 2'b00};

        resetn = 1'b0; sel = 1'b1; scan_req = 1'b1; scan_addr = 12'h200;
        wstrb = 4'b0011; addr = 12'h010; wdata = 16'h1234;
        fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we_mask", {ram_we, ram_wmask}, 0);
        chk("rst_ram_addr_wdata", {ram_addr, ram_wdata}, 0);
        chk("rst_ready", ready, 0);
        chk("rst_scan_valid", scan_valid, 0);
        chk("rst_fill", {fill_busy, fill_done}, 0);
        chk("rst_rdata", rdata, 0);
        sel = 1'b0; scan_req = 1'b0; wstrb = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            nop = (tv[i].strb[1:0] == 2'b00) && (tv[i].strb[3:2] != 2'b00);
            cpu_op(tv[i], lat, rd, en1, we1, m1, a1);
            chk({tv[i].name, "_lat"}, lat, tv[i].lat);
            if (nop) chk({tv[i].name, "_no_access"}, en1, 0);
            else chk({tv[i].name, "_g1_access"}, {en1, we1, m1, a1}, {1'b1, tv[i].strb[1:0] != 2'b00, tv[i].m, tv[i].a});
            if (tv[i].strb == 4'b0000) chk({tv[i].name, "_rdata"}, rd, tv[i].rd);
            @(negedge clk);
            chk({tv[i].name, "_ready_pulse"}, ready, 0);
        end

        // Reset during a read: transaction abandoned, no ready afterwards.
        @(negedge clk);
        sel = 1'b1; wstrb = '0; addr = 12'h3FF;
        @(negedge clk);
        resetn = 1'b0; sel = 1'b0;
        @(negedge clk);
        chk("midrst_ram_en", ram_en, 0);
        resetn = 1'b1;
        rdy_n = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready) rdy_n++;
        end
        chk("midrst_no_ready", rdy_n, 0);
        chk("midrst_rdata_clr", rdata, 0);

        // Scan burst 0x200..0x209 with a CPU read of 0x010 pending.
        @(negedge clk);
        scan_req = 1'b1; scan_addr = 12'h200; sel = 1'b1; wstrb = '0; addr = 12'h010;
        vcnt = 0; vfirst = -1; cpu_at = -1; rdy_at = -1; rdy_n = 0; rd = '0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (scan_valid) begin
                if (vfirst < 0) vfirst = c;
                vcnt++;
                chk("scan_rdata", scan_rdata, 16'hC200 + 16'(c - 2));
            end
            if (ram_en && c <= 10) chk("scan_ram_addr", {ram_we, ram_addr}, {1'b0, 12'h200 + 12'(c - 1)});
            if (ram_en && ram_addr == 12'h010 && cpu_at < 0) cpu_at = c;
            if (ready) begin
                rdy_n++;
                if (rdy_at < 0) begin rdy_at = c; rd = rdata; end
                sel = 1'b0;
            end
            if (c <= 9) scan_addr = 12'h200 + 12'(c);
            if (c == 10) scan_req = 1'b0;
        end
        sel = 1'b0;
        chk("scan_valid_count", vcnt, 10);
        chk("scan_valid_first", vfirst, 2);
        chk("scan_cpu_grant", cpu_at, 11);
        chk("scan_cpu_ready_at", rdy_at, 13);
        chk("scan_cpu_ready_n", rdy_n, 1);
        chk("scan_cpu_rdata", rd, 16'h125A);

`ifdef VRAM_ARB_FILL_EN
        // Fill wrapping past the top of the address space.
        @(negedge clk);
        log_q.delete();
        fill_start = 1'b1; fill_base = 12'hFFE; fill_count = 13'd4; fill_value = 16'h0720;
        done_n = 0; done_at = -1; busy_n = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (fill_done) begin done_n++; if (done_at < 0) done_at = c; end
            if (fill_busy) busy_n++;
            if (c == 1) fill_start = 1'b0;
        end
        wrap_a[0] = 12'hFFE; wrap_a[1] = 12'hFFF; wrap_a[2] = 12'h000; wrap_a[3] = 12'h001;
        chk("wrap_done_n", done_n, 1);
        chk("wrap_done_at", done_at, 5);
        chk("wrap_busy_cycles", busy_n, 4);
        chk("wrap_n_writes", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size())
                chk("wrap_write", {log_q[i].we, log_q[i].m, log_q[i].a, log_q[i].d}, {1'b1, 2'b11, wrap_a[i], 16'h0720});
        chk("wrap_mem_000", mem[12'h000], 16'h0720);
        chk("wrap_mem_002", mem[12'h002], 16'hC002);

        // Zero-length fill: done next cycle, no writes.
        @(negedge clk);
        log_q.delete();
        fill_start = 1'b1; fill_base = 12'h500; fill_count = '0;
        @(negedge clk);
        fill_start = 1'b0;
        chk("zero_done", {fill_busy, fill_done}, 2'b01);
        @(negedge clk);
        chk("zero_done_pulse", fill_done, 0);
        repeat (2) @(negedge clk);
        chk("zero_no_writes", log_q.size(), 0);

        // Round robin: 8-word fill, CPU write joins in the second fill cycle, re-start while busy.
        @(negedge clk);
        log_q.delete();
        fill_start = 1'b1; fill_base = 12'h100; fill_count = 13'd8; fill_value = 16'h1111;
        done_at = -1; rdy_at = -1; rdy_n = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (fill_done && done_at < 0) done_at = c;
            if (ready) begin rdy_n++; if (rdy_at < 0) rdy_at = c; sel = 1'b0; wstrb = '0; end
            if (c == 1) fill_start = 1'b0;
            if (c == 2) begin sel = 1'b1; wstrb = 4'b0011; addr = 12'h050; wdata = 16'hCAFE; end
            if (c == 3) begin fill_start = 1'b1; fill_base = 12'h300; fill_count = 13'd2; fill_value = 16'h2222; end
            if (c == 4) fill_start = 1'b0;
        end
        sel = 1'b0;
        chk("rr_n_access", log_q.size(), 9);
        if (log_q.size() >= 3) begin
            chk("rr_0_fill", {log_q[0].a, log_q[0].d}, {12'h100, 16'h1111});
            chk("rr_1_cpu",  {log_q[1].a, log_q[1].d}, {12'h050, 16'hCAFE});
            chk("rr_2_fill", {log_q[2].a, log_q[2].d}, {12'h101, 16'h1111});
        end
        n1111 = 0; n2222 = 0;
        foreach (log_q[i]) begin
            if (log_q[i].d == 16'h2222) n2222++;
            if (log_q[i].d == 16'h1111) begin
                chk("rr_fill_addr", log_q[i].a, 12'h100 + 12'(n1111));
                n1111++;
            end
        end
        chk("rr_fill_writes", n1111, 8);
        chk("rr_restart_ignored", n2222, 0);
        chk("rr_cpu_ready_at", rdy_at, 4);
        chk("rr_cpu_ready_n", rdy_n, 1);
        chk("rr_done_at", done_at, 10);
        chk("rr_mem_050", mem[12'h050], 16'hCAFE);
`else
        // Fill engine absent: start pulses do nothing.
        @(negedge clk);
        log_q.delete();
        fill_start = 1'b1; fill_base = 12'h100; fill_count = 13'd4; fill_value = 16'h1111;
        done_n = 0; busy_n = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (fill_done) done_n++;
            if (fill_busy) busy_n++;
            fill_start = 1'b0;
        end
        chk("nofill_busy", busy_n, 0);
        chk("nofill_done", done_n, 0);
        chk("nofill_no_writes", log_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Single-clock access controller that shares one 16-bit single-port synchronous video RAM between three requesters.
- Requesters are the display scanout fetcher, the CPU MMIO bus port (picosoc sel/ready style) and a hardware fill engine used for screen clear and attribute fill.
- Scanout has absolute priority. CPU and fill share the remaining RAM cycles round-robin.
- Sits between the video core's text/font fetch logic and the VRAM/font dpram instances.

Parameters:
- AW, 12, RAM word-address width (4096 x 16-bit words).

Ports:
- clk  input  1  system/pixel clock; all logic on posedge.
- resetn  input  1  asynchronous, active-low reset.
- scan_req  input  1  scanout read request, one word per asserted cycle.
- scan_addr  input  AW  scanout word address.
- scan_valid  output  1  scanout read data valid.
- scan_rdata  output  16  scanout read data.
- sel  input  1  CPU access select; held until ready.
- wstrb  input  4  CPU byte strobes. Only [1:0] are used. All zero means read.
- addr  input  AW  CPU word address.
- wdata  input  16  CPU write data.
- ready  output  1  CPU completion pulse.
- rdata  output  16  CPU read data, registered.
- fill_start  input  1  fill start pulse.
- fill_base  input  AW  first fill address.
- fill_count  input  AW+1  number of words to write.
- fill_value  input  16  fill word.
- fill_busy  output  1  fill in progress.
- fill_done  output  1  one-cycle pulse when fill completes.
- ram_en  output  1  RAM access enable.
- ram_we  output  1  RAM write enable.
- ram_wmask  output  2  RAM byte write mask.
- ram_addr  output  AW  RAM address.
- ram_wdata  output  16  RAM write data.
- ram_rdata  input  16  RAM read data, valid one cycle after ram_en with ram_we=0.

Behaviour:
- Reset (async, resetn=0):
  - ram_en, ram_we, ram_wmask, ready, scan_valid, fill_busy and fill_done are all 0.
  - rdata, ram_addr and ram_wdata are 0.
  - CPU FSM is in IDLE; round-robin pointer points to CPU.
  - Reset mid-transaction abandons the transaction; no pulse is emitted after release.
- Grant cycle G: arbitration is combinational from current inputs and state. RAM outputs are registered, so the access appears on ram_* in G+1.
- Priority:
  - scan_req=1 always wins G.
  - Otherwise, if both CPU and fill are pending, grant the one not granted last, then flip the pointer.
  - If only one is pending, it is granted.
  - If none is pending, ram_en=0 in G+1.
- Scanout: fixed latency. scan_valid=1 in G+2; scan_rdata = ram_rdata (pass-through). Back-to-back requests give back-to-back valid.
- CPU FSM states: IDLE, PEND, WR_ACK, RD_WAIT, RD_ACK, HOLD.
  - IDLE: sel=1 makes the CPU pending in the same cycle (eligible for grant) and the FSM enters PEND unless granted.
  - Granted write (wstrb[1:0]!=0): ram_we=1, ram_wmask=wstrb[1:0], transition to WR_ACK. ready=1 in G+2.
  - Write with wstrb[1:0]=0 but wstrb[3:2]!=0: not a RAM access; ready pulses next cycle.
  - Granted read: transition to RD_WAIT. rdata is loaded from ram_rdata at the end of G+2. ready=1 in G+3.
  - After ready, HOLD for one cycle, ignoring sel, then IDLE.
  - ready is always a single-cycle pulse.
  - sel dropped while in PEND: request withdrawn, return to IDLE, no ready. Once granted, the access completes and ready pulses regardless of sel.
- Fill engine:
  - fill_start while idle with fill_count>0: latch base, count and value, and set fill_busy the next cycle.
  - Each fill grant writes fill_value with wmask=11 to the current address. Address increments mod 2^AW, so it wraps from 2^AW-1 to 0.
  - After the last write is issued, fill_busy=0 and fill_done=1 for one cycle in G+1.
  - fill_count=0: no writes; fill_done pulses the cycle after fill_start.
  - fill_start while busy is ignored.
- Starvation: the CPU and fill engine may stall indefinitely under continuous scan_req. This is acceptable because scanout leaves the RAM idle during blanking.

Optional Feature:
- VRAM_ARB_FILL_EN defined: fill engine present as described.
- Not defined: fill inputs are ignored, fill_busy=0 and fill_done=0 constantly, and the CPU is the sole non-scan requester with no round-robin state.

Test Plan:
- Reset: hold resetn=0 with sel=1 and scan_req=1 -> ram_en=0, ready=0, scan_valid=0, fill_busy=0. After release, the first access begins normally.
- CPU write/read: sel with addr=0x010, wstrb=0011, wdata=0xA55A, no scan:
  - G+1: ram_en=1, ram_we=1, ram_wmask=11, ram_addr=0x010.
  - ready pulses at G+2.
  - A following read of 0x010 gives ready at G+3 with rdata=0xA55A.
- Byte strobe: wstrb=0010, wdata=0x12FF onto 0xA55A -> ram_wmask=10; readback=0x125A.
- Scan priority: scan_req held 10 cycles at addresses 0x200..0x209 with a CPU read pending -> no CPU grant during the burst. scan_valid is high for 10 consecutive cycles starting 2 cycles after the first request, returning words in address order. The CPU is granted in the first cycle after scan_req falls.
- Fill wrap: fill_base=0xFFE, fill_count=4, fill_value=0x0720 -> writes to 0xFFE, 0xFFF, 0x000, 0x001; fill_done is a single pulse; 0x002 is unchanged.
- Round-robin: fill of 8 words running while the CPU issues a write, no scan -> RAM grants alternate fill/CPU/fill. CPU ready arrives no later than G+3 from the first pending cycle.
